video_timing_gen: RTL and testbench



---
 rtl/video_timing_gen.sv | 189 ++++++++++++++++++
 tb/tb_video_timing_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Video timing source: free-running raster counters with frame-aligned start/stop,
// registered sync/de/data/coordinate outputs. Define VTG_COLORBAR_EN for 8-bar test pattern.
module video_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int W_DATA   = 24
) (
  input  logic              vo_clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [W_DATA-1:0] bg_color,
  output logic              vo_vsync,
  output logic              vo_hsync,
  output logic              vo_de,
  output logic [W_DATA-1:0] vo_data,
  output logic [15:0]       vo_x,
  output logic [15:0]       vo_y,
  output logic              frame_start,
  output logic              busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        HS_ACT   = 1'(HS_POL);
  localparam logic        VS_ACT   = 1'(VS_POL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STOP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_hcnt;
  logic [15:0] r_vcnt;
  logic [15:0] w_hcnt_nxt;
  logic [15:0] w_vcnt_nxt;
  logic        w_line_end;
  logic        w_eof;
  logic        w_run;
  logic        w_de;
  logic        w_hs;
  logic        w_vs;
  logic [W_DATA-1:0] w_pix;

  assign w_run = (r_state != S_IDLE);
  assign busy  = w_run;

  always_comb begin
    w_line_end = (r_hcnt == H_LAST);
    w_eof      = w_line_end && (r_vcnt == V_LAST);
    w_hcnt_nxt = w_line_end ? '0 : r_hcnt + 16'd1;
    w_vcnt_nxt = r_vcnt;
    if (w_line_end) begin
      w_vcnt_nxt = (r_vcnt == V_LAST) ? '0 : r_vcnt + 16'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (en) w_state_nxt = S_RUN;
      S_RUN:  if (!en) w_state_nxt = S_STOP;
      S_STOP: begin
        // Stop only takes effect on the last pixel of the frame; en returning earlier resumes seamlessly.
        if (w_eof) w_state_nxt = en ? S_RUN : S_IDLE;
        else if (en) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge vo_clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge vo_clk or negedge rstn) begin
    if (!rstn) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (!w_run) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else begin
      r_hcnt <= w_hcnt_nxt;
      r_vcnt <= w_vcnt_nxt;
    end
  end

  always_comb begin
    w_de = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
    w_hs = (r_hcnt >= HS_START) && (r_hcnt < HS_END);
    w_vs = (r_vcnt >= VS_START) && (r_vcnt < VS_END);
  end

`ifdef VTG_COLORBAR_EN
  localparam int          BW      = H_ACTIVE / 8;
  localparam int          CW      = W_DATA / 3;
  localparam logic [15:0] BW_LAST = 16'(BW - 1);

  if (H_ACTIVE < 8) begin : g_bar_width_check
    $error("video_timing_gen: H_ACTIVE must be at least 8 for colour bars");
  end

  logic [15:0] r_bcnt;
  logic [2:0]  r_bidx;
  logic        w_unused_bg;

  assign w_unused_bg = ^bg_color;

  // Bar index tracks hcnt without a divider; the last bar saturates and soaks up the remainder.
  always_ff @(posedge vo_clk or negedge rstn) begin
    if (!rstn) begin
      r_bcnt <= '0;
      r_bidx <= '0;
    end else if (!w_run || w_line_end) begin
      r_bcnt <= '0;
      r_bidx <= '0;
    end else if (r_bidx != 3'd7) begin
      if (r_bcnt == BW_LAST) begin
        r_bcnt <= '0;
        r_bidx <= r_bidx + 3'd1;
      end else begin
        r_bcnt <= r_bcnt + 16'd1;
      end
    end
  end

  // Bar order white,yellow,cyan,green,magenta,red,blue,black maps to R=~i[1], G=~i[2], B=~i[0].
  always_comb begin
    w_pix = W_DATA'({{CW{~r_bidx[1]}}, {CW{~r_bidx[2]}}, {CW{~r_bidx[0]}}});
  end
`else
  always_comb begin
    w_pix = bg_color;
  end
`endif

  always_ff @(posedge vo_clk or negedge rstn) begin
    if (!rstn) begin
      vo_de       <= 1'b0;
      vo_hsync    <= ~HS_ACT;
      vo_vsync    <= ~VS_ACT;
      vo_data     <= '0;
      vo_x        <= '0;
      vo_y        <= '0;
      frame_start <= 1'b0;
    end else if (w_run) begin
      vo_de       <= w_de;
      vo_hsync    <= w_hs ? HS_ACT : ~HS_ACT;
      vo_vsync    <= w_vs ? VS_ACT : ~VS_ACT;
      vo_data     <= w_de ? w_pix : '0;
      vo_x        <= w_de ? r_hcnt : '0;
      vo_y        <= w_de ? r_vcnt : '0;
      frame_start <= w_de && (r_hcnt == '0) && (r_vcnt == '0);
    end else begin
      vo_de       <= 1'b0;
      vo_hsync    <= ~HS_ACT;
      vo_vsync    <= ~VS_ACT;
      vo_data     <= '0;
      vo_x        <= '0;
      vo_y        <= '0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small raster (24x8, 192 clks/frame) against a frame-position model.
module tb_video_timing_gen;

  localparam int HA = 16, HF = 2, HSY = 3, HB = 3;
  localparam int VA = 4, VF = 1, VSY = 2, VB = 1;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FRAME = HT * VT;

  logic        vo_clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic [23:0] bg_color = '0;
  logic        vo_vsync, vo_hsync, vo_de, frame_start, busy;
  logic [23:0] vo_data;
  logic [15:0] vo_x, vo_y;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1), .VS_POL(1), .W_DATA(24)
  ) u_dut (
    .vo_clk(vo_clk), .rstn(rstn), .en(en), .bg_color(bg_color),
    .vo_vsync(vo_vsync), .vo_hsync(vo_hsync), .vo_de(vo_de), .vo_data(vo_data),
    .vo_x(vo_x), .vo_y(vo_y), .frame_start(frame_start), .busy(busy)
  );

  always #5 vo_clk = ~vo_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: generator either idle or at a position 0..FRAME-1 in the frame; m_stop = stop pending.
  bit m_act  = 1'b0;
  bit m_stop = 1'b0;
  int m_pos  = 0;
  int cyc    = 0;
  int last_fs = -1;
  int fs_gap  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [23:0] pix_ref(input int h);
`ifdef VTG_COLORBAR_EN
    logic [23:0] bars [8];
    int b;
    bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
    b = h / (HA / 8);
    if (b > 7) b = 7;
    return bars[b];
`else
    return (h >= 0) ? bg_color : 24'h0;
`endif
  endfunction

  task automatic step();
    int h, v;
    bit e_de, e_hs, e_vs, e_fs;
    logic [15:0] ex, ey;
    logic [23:0] ed;
    @(posedge vo_clk);
    cyc++;
    e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_fs = 1'b0;
    ex = '0; ey = '0; ed = '0;
    if (!rstn) begin
      m_act = 1'b0; m_pos = 0; m_stop = 1'b0;
    end else begin
      if (m_act) begin
        h = m_pos % HT;
        v = m_pos / HT;
        e_de = (h < HA) && (v < VA);
        e_hs = (h >= HA + HF) && (h < HA + HF + HSY);
        e_vs = (v >= VA + VF) && (v < VA + VF + VSY);
        e_fs = (m_pos == 0);
        if (e_de) begin
          ex = 16'(h); ey = 16'(v); ed = pix_ref(h);
        end
      end
      if (!m_act) begin
        if (en) begin
          m_act = 1'b1; m_pos = 0; m_stop = 1'b0;
        end
      end else if (m_stop && m_pos == FRAME - 1 && !en) begin
        m_act = 1'b0; m_pos = 0; m_stop = 1'b0;
      end else begin
        m_stop = !en;
        m_pos = (m_pos + 1) % FRAME;
      end
    end
    #1;
    check_val("de",    32'(vo_de),       32'(e_de));
    check_val("hsync", 32'(vo_hsync),    32'(e_hs));
    check_val("vsync", 32'(vo_vsync),    32'(e_vs));
    check_val("fs",    32'(frame_start), 32'(e_fs));
    check_val("busy",  32'(busy),        32'(m_act));
    check_val("x",     32'(vo_x),        32'(ex));
    check_val("y",     32'(vo_y),        32'(ey));
    check_val("data",  32'(vo_data),     32'(ed));
    if (frame_start) begin
      if (last_fs >= 0) fs_gap = cyc - last_fs;
      last_fs = cyc;
    end
  endtask

  initial begin
    int nde, nhs, nvs, guard;

    // Reset held across a few edges
    step(); step();
    rstn = 1'b1;
    repeat (3) step();

    // Start and one clean frame with fixed colour
    bg_color = 24'h123456;
    en = 1'b1;
    step();
    step();
    check_val("first_fs", 32'(frame_start), 32'd1);
    nde = int'(vo_de); nhs = int'(vo_hsync); nvs = int'(vo_vsync);
    for (int i = 1; i < FRAME; i++) begin
      step();
      nde += int'(vo_de); nhs += int'(vo_hsync); nvs += int'(vo_vsync);
    end
    check_val("de_per_frame",    32'(nde), 32'd64);
    check_val("hs_per_frame",    32'(nhs), 32'd24);
    check_val("vs_per_frame",    32'(nvs), 32'd48);
    step();
    check_val("fs_period", 32'(fs_gap), 32'(FRAME));

    // Stop requested on line 1: frame must complete, then idle
    guard = 0;
    while (m_pos != HT + 6 && guard < 2 * FRAME) begin step(); guard++; end
    en = 1'b0;
    guard = 0;
    while (busy && guard < 2 * FRAME) begin step(); guard++; end
    check_val("stop_idle", 32'(busy), 32'd0);
    repeat (4) step();

    // en 1->0->1 inside a frame: no gap in frame_start
    en = 1'b1;
    last_fs = -1; fs_gap = 0;
    guard = 0;
    while (m_pos != 100 && guard < 2 * FRAME) begin step(); guard++; end
    en = 1'b0;
    repeat (20) step();
    en = 1'b1;
    repeat (2 * FRAME) step();
    check_val("no_gap_period", 32'(fs_gap), 32'(FRAME));

    // Asynchronous reset mid-line while de is high
    guard = 0;
    while (!(vo_de && (m_pos % HT) == 6) && guard < 2 * FRAME) begin step(); guard++; end
    check_val("pre_rst_de", 32'(vo_de), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check_val("rst_de",    32'(vo_de),    32'd0);
    check_val("rst_hsync", 32'(vo_hsync), 32'd0);
    check_val("rst_vsync", 32'(vo_vsync), 32'd0);
    check_val("rst_data",  32'(vo_data),  32'd0);
    check_val("rst_x",     32'(vo_x),     32'd0);
    check_val("rst_busy",  32'(busy),     32'd0);
    step(); step();
    #3 rstn = 1'b1;
    step(); step();
    check_val("rst_restart_fs", 32'(frame_start), 32'd1);

    // Randomised run control and per-pixel colour
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) en = ~en;
      bg_color = 24'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
